word_splitter_stream: RTL



---
 rtl/splitter_pkg.sv | 18 +
 rtl/chunk_ext.sv | 23 ++
 rtl/word_splitter_stream.sv | 124 ++++++++++++
 3 files changed

// File: rtl/splitter_pkg.sv
// Shared types and sizing helpers for the word splitter stream.
package splitter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int chunks(input int in_w, input int chunk_w);
        return in_w / chunk_w;
    endfunction

    // A single-chunk word still gets a one-bit index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_ext.sv
// Combinational CHUNK_W -> OUT_W extender.
// Zero-extends by default; sign-extends when WORD_SPLITTER_SIGN_EXT_EN is defined.
module chunk_ext #(
    parameter int CHUNK_W = 8,
    parameter int OUT_W   = 16
) (
    input  logic [CHUNK_W-1:0] chunk_in,
    output logic [OUT_W-1:0]   data_out
);

    generate
        if (OUT_W > CHUNK_W) begin : g_pad
`ifdef WORD_SPLITTER_SIGN_EXT_EN
            assign data_out = {{(OUT_W-CHUNK_W){chunk_in[CHUNK_W-1]}}, chunk_in};
`else
            assign data_out = {{(OUT_W-CHUNK_W){1'b0}}, chunk_in};
`endif
        end else begin : g_same
            assign data_out = chunk_in;
        end
    endgenerate

endmodule

// File: rtl/word_splitter_stream.sv
// Splits an IN_W-bit word into CHUNK_W-bit chunks emitted one per cycle on a valid/ready stream.
// Extension mode is chosen in chunk_ext via WORD_SPLITTER_SIGN_EXT_EN.
module word_splitter_stream
    import splitter_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int CHUNK_W = 8,
    parameter int OUT_W   = 16
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [IN_W-1:0]                             in_data,
    input  logic                                        in_msb_first,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [OUT_W-1:0]                            out_data,
    output logic [idx_w(chunks(IN_W, CHUNK_W))-1:0]     out_idx,
    output logic                                        out_last
);

    localparam int N  = chunks(IN_W, CHUNK_W);
    localparam int IW = idx_w(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e            state_q, state_d;
    logic [IN_W-1:0]   word_q, word_d;
    logic              msb_q, msb_d;
    logic [IW-1:0]     count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [IW-1:0]     out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;

    logic              out_fire;
    logic              in_fire;
    logic [CHUNK_W-1:0] chunk_arr [N];
    logic [CHUNK_W-1:0] chunk_sel;
    logic [OUT_W-1:0]   chunk_wide;

    // Accepting on the last beat keeps the output stream gap-free across words.
    assign out_fire = out_valid_q && out_ready;
    assign in_ready = (state_q == IDLE) || (out_fire && out_last_q);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        msb_d   = msb_q;
        count_d = count_q;
        if (in_fire) begin
            state_d = SEND;
            word_d  = in_data;
            msb_d   = in_msb_first;
            count_d = '0;
        end else if (out_fire) begin
            if (out_last_q) begin
                state_d = IDLE;
                count_d = '0;
            end else begin
                count_d = count_q + IW'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chunk
            assign chunk_arr[gi] = word_d[gi*CHUNK_W +: CHUNK_W];
        end
    endgenerate

    always_comb begin
        out_idx_d = '0;
        if (state_d == SEND) begin
            out_idx_d = msb_d ? (LAST_IDX - count_d) : count_d;
        end
    end

    assign chunk_sel = chunk_arr[out_idx_d];

    chunk_ext #(
        .CHUNK_W (CHUNK_W),
        .OUT_W   (OUT_W)
    ) u_chunk_ext (
        .chunk_in (chunk_sel),
        .data_out (chunk_wide)
    );

    always_comb begin
        out_valid_d = (state_d == SEND);
        out_data_d  = out_valid_d ? chunk_wide : '0;
        out_last_d  = out_valid_d && (count_d == LAST_IDX);
    end

    // Outputs are registered from next-state values, so backpressure holds them naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            msb_q       <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            msb_q       <= msb_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule
